dmem_access_ctrl: RTL and testbench

// - Sequences data-memory loads/stores for the MEM stage over a req/ack handshake with variable-latency memory.
// - Stalls the pipeline while a request is outstanding; aligns and extends load data by func3 before it reaches the MEM/WB register.
// - Builds store byte strobes. Reports misaligned, illegal-func3 and timeout faults.

---
 rtl/riscv_mem_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/dmem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the data-memory access path: FSM states, RV32I
// load/store width codes (func3) and fault cause codes.
// No ports; imported by lsu_lane_align and dmem_access_ctrl.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for loads/stores: store strobes and replicated
// write data, aligned/extended load data, illegal-func3 and misalignment flags.
// Ports: func3, we, addr_lo, wdata, rdata in; wstrb, lane_wdata, load_ext, illegal, misaligned out.
module lsu_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_ext,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  assign byte_sh = rdata >> {addr_lo, 3'b000};
  assign half_sh = rdata >> {addr_lo[1], 4'b0000};

  always_comb begin
    wstrb      = 4'b0000;
    lane_wdata = wdata;
    load_ext   = rdata;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (func3)
      F3_B: begin
        load_ext   = {{24{byte_sh[7]}}, byte_sh[7:0]};
        lane_wdata = {4{wdata[7:0]}};
        wstrb      = we ? (4'b0001 << addr_lo) : 4'b0000;
      end
      F3_H: begin
        load_ext   = {{16{half_sh[15]}}, half_sh[15:0]};
        lane_wdata = {2{wdata[15:0]}};
        wstrb      = we ? (4'b0011 << addr_lo) : 4'b0000;
        misaligned = addr_lo[0];
      end
      F3_W: begin
        load_ext   = rdata;
        lane_wdata = wdata;
        wstrb      = we ? 4'b1111 : 4'b0000;
        misaligned = |addr_lo;
      end
      // Unsigned widths exist for loads only; a store with these codes is illegal.
      F3_BU: begin
        load_ext = {24'h0, byte_sh[7:0]};
        illegal  = we;
      end
      F3_HU: begin
        load_ext   = {16'h0, half_sh[15:0]};
        illegal    = we;
        misaligned = addr_lo[0];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues req/ack transactions, stalls the
// pipeline while outstanding, latches aligned load data, reports faults.
// Ports: clk, rst (async active-low); mem_* request from MEM; dm_* memory side; stall/done/exc_* to pipeline.
module dmem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        exc_valid,
  output logic [1:0]  exc_cause
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       addr_lo_q;
  logic [1:0]       cause_q;

  // In IDLE the lane logic decodes the live request; once accepted it
  // decodes the captured copy so the load path does not depend on the
  // pipeline holding addr/func3 steady.
  logic        in_idle;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_lo;
  logic        sel_we;
  logic [3:0]  a_wstrb;
  logic [31:0] a_wdata;
  logic [31:0] a_load;
  logic        a_illegal;
  logic        a_misaligned;
  logic        fault;

  assign in_idle = (state == S_IDLE);
  assign sel_f3  = in_idle ? func3     : f3_q;
  assign sel_lo  = in_idle ? addr[1:0] : addr_lo_q;
  assign sel_we  = in_idle ? mem_we    : dm_we;

  lsu_lane_align u_align (
    .func3      (sel_f3),
    .we         (sel_we),
    .addr_lo    (sel_lo),
    .wdata      (wdata),
    .rdata      (dm_rdata),
    .wstrb      (a_wstrb),
    .lane_wdata (a_wdata),
    .load_ext   (a_load),
    .illegal    (a_illegal),
    .misaligned (a_misaligned)
  );

  assign fault = a_illegal | a_misaligned;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (mem_valid) nxt = fault ? S_ERR : S_REQ;
      S_REQ: begin
        if (dm_ack)              nxt = S_DONE;
        else if (cnt == CNT_LAST) nxt = S_ERR;
      end
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // stall is gated by rst so it drops the moment reset asserts, even if
  // mem_valid is still high while the FSM sits in IDLE.
  assign dm_req    = (state == S_REQ);
  assign stall     = rst & ((in_idle & mem_valid) | (state == S_REQ));
  assign done      = (state == S_DONE);
  assign exc_valid = (state == S_ERR);
  assign exc_cause = cause_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      f3_q      <= 3'b000;
      addr_lo_q <= 2'b00;
      cause_q   <= EXC_NONE;
      dm_we     <= 1'b0;
      dm_addr   <= 32'h0;
      dm_wdata  <= 32'h0;
      dm_wstrb  <= 4'b0000;
      load_data <= 32'h0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            if (fault) begin
              cause_q <= a_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
            end else begin
              cnt       <= '0;
              f3_q      <= func3;
              addr_lo_q <= addr[1:0];
              dm_we     <= mem_we;
              dm_addr   <= {addr[31:2], 2'b00};
              dm_wdata  <= a_wdata;
              dm_wstrb  <= a_wstrb;
            end
          end
        end
        S_REQ: begin
          if (dm_ack) begin
            cnt <= '0;
            if (!dm_we) load_data <= a_load;
          end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            cause_q <= EXC_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, reset-in-REQ
// sequence, then randomized ops checked against a behavioural model.
// Runs the DUT with MAX_WAIT=4 so timeouts are reachable quickly.
module tb_dmem_access_ctrl;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_we;
  logic [2:0]  func3;
  logic [31:0] addr, wdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        done, exc_valid;
  logic [1:0]  exc_cause;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MAX_WAIT(MAXW), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_we(mem_we), .func3(func3), .addr(addr), .wdata(wdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .stall(stall), .load_data(load_data), .done(done),
    .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  typedef struct {
    int          req;
    int          stl;
    logic        dn;
    logic [1:0]  cause;
    logic [31:0] ld;
    logic [31:0] a;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wd;
  } res_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    res_t        exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one op and acts as the memory: ack in REQ cycle number dly+1
  // (never if dly >= MAXW). Samples #1 into the low clock phase.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly,
                        output res_t o, output logic fin);
    o = '{default: 0};
    fin = 1'b0;
    @(negedge clk);
    mem_valid = 1'b1; mem_we = we; func3 = f3; addr = a; wdata = wd;
    dm_rdata = rd; dm_ack = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      dm_ack = 1'b0;
      if (stall) o.stl++;
      if (dm_req) begin
        o.req++;
        o.a = dm_addr; o.we = dm_we; o.strb = dm_wstrb; o.wd = dm_wdata;
        if (o.req == dly + 1) dm_ack = 1'b1;
      end
      if (done || exc_valid) begin
        o.dn = done;
        o.cause = exc_valid ? exc_cause : 2'b00;
        o.ld = load_data;
        fin = 1'b1;
        mem_valid = 1'b0;
        dm_ack = done;   // spurious ack outside REQ must be ignored
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic compare(input string tag, input res_t o, input logic fin, input res_t e);
    if (!fin) begin
      tests++; fails++;
      $display("FAIL %s.finish: no done/exc within budget", tag);
      mem_valid = 1'b0;
      return;
    end
    check({tag, ".req_cycles"}, o.req, e.req);
    check({tag, ".stall_cycles"}, o.stl, e.stl);
    check({tag, ".done"}, o.dn, e.dn);
    check({tag, ".exc_cause"}, o.cause, e.cause);
    check({tag, ".load_data"}, o.ld, e.ld);
    if (e.req > 0) begin
      check({tag, ".dm_addr"}, o.a, e.a);
      check({tag, ".dm_we"}, o.we, e.we);
      check({tag, ".dm_wstrb"}, o.strb, e.strb);
      if (e.we) check({tag, ".dm_wdata"}, o.wd, e.wd);
    end
  endtask

  // Behavioural reference built from the access rules with plain arithmetic.
  function automatic res_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int dly,
                                 input logic [31:0] prev_ld);
    res_t e;
    bit ill, mis;
    int size, off;
    logic [31:0] v;
    e = '{default: 0};
    e.ld = prev_ld;
    if (we) ill = (f3 > 3'd2);
    else    ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(a % 4);
    mis  = !ill && ((a % size) != 0);
    if (ill)            e.cause = 2'b11;
    else if (mis)       e.cause = 2'b01;
    else if (dly >= MAXW) begin e.req = MAXW; e.cause = 2'b10; end
    else begin e.req = dly + 1; e.dn = 1'b1; end
    e.stl = e.req + 1;
    e.a  = a & ~32'd3;
    e.we = we;
    if (we) begin
      e.strb = 4'(((1 << size) - 1) << off);
      if (size == 1)      e.wd = (wd & 32'hFF) * 32'h01010101;
      else if (size == 2) e.wd = (wd & 32'hFFFF) * 32'h00010001;
      else                e.wd = wd;
    end
    if (e.dn && !we) begin
      if (size == 1) begin
        v = (rd >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = (rd >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else v = rd;
      e.ld = v;
    end
    return e;
  endfunction

  vec_t vecs[14];

  initial begin
    res_t o, e;
    logic fin;
    logic [31:0] cur_ld;

    //        we  f3     addr        wdata        rdata        dly  req stl dn cause ld            addr        we   strb     wdata
    vecs[0]  = '{0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 2, '{3, 4, 1, 2'b00, 32'hDEADBEEF, 32'h100, 0, 4'b0000, 32'h0}};
    vecs[1]  = '{0, 3'd0, 32'h103, 32'h0,        32'h80123456, 0, '{1, 2, 1, 2'b00, 32'hFFFFFF80, 32'h100, 0, 4'b0000, 32'h0}};
    vecs[2]  = '{0, 3'd4, 32'h103, 32'h0,        32'h80123456, 1, '{2, 3, 1, 2'b00, 32'h00000080, 32'h100, 0, 4'b0000, 32'h0}};
    vecs[3]  = '{1, 3'd1, 32'h202, 32'h00001234, 32'h0,        0, '{1, 2, 1, 2'b00, 32'h00000080, 32'h200, 1, 4'b1100, 32'h12341234}};
    vecs[4]  = '{0, 3'd2, 32'h101, 32'h0,        32'h0,        0, '{0, 1, 0, 2'b01, 32'h00000080, 32'h0,   0, 4'b0000, 32'h0}};
    vecs[5]  = '{0, 3'd3, 32'h100, 32'h0,        32'h0,        0, '{0, 1, 0, 2'b11, 32'h00000080, 32'h0,   0, 4'b0000, 32'h0}};
    vecs[6]  = '{0, 3'd2, 32'h104, 32'h0,        32'h0,       99, '{4, 5, 0, 2'b10, 32'h00000080, 32'h104, 0, 4'b0000, 32'h0}};
    vecs[7]  = '{0, 3'd1, 32'h102, 32'h0,        32'h80010000, 0, '{1, 2, 1, 2'b00, 32'hFFFF8001, 32'h100, 0, 4'b0000, 32'h0}};
    vecs[8]  = '{0, 3'd5, 32'h102, 32'h0,        32'h80017FFF, 3, '{4, 5, 1, 2'b00, 32'h00008001, 32'h100, 0, 4'b0000, 32'h0}};
    vecs[9]  = '{1, 3'd0, 32'h201, 32'h000000AB, 32'h0,        0, '{1, 2, 1, 2'b00, 32'h00008001, 32'h200, 1, 4'b0010, 32'hABABABAB}};
    vecs[10] = '{1, 3'd2, 32'h300, 32'h11223344, 32'h0,        1, '{2, 3, 1, 2'b00, 32'h00008001, 32'h300, 1, 4'b1111, 32'h11223344}};
    vecs[11] = '{1, 3'd4, 32'h300, 32'h0,        32'h0,        0, '{0, 1, 0, 2'b11, 32'h00008001, 32'h0,   0, 4'b0000, 32'h0}};
    vecs[12] = '{1, 3'd1, 32'h203, 32'h0,        32'h0,        0, '{0, 1, 0, 2'b01, 32'h00008001, 32'h0,   0, 4'b0000, 32'h0}};
    vecs[13] = '{0, 3'd7, 32'h101, 32'h0,        32'h0,        0, '{0, 1, 0, 2'b11, 32'h00008001, 32'h0,   0, 4'b0000, 32'h0}};

    rst = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; func3 = 3'd0;
    addr = 32'h0; wdata = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
    #2;
    check("rst.dm_req", dm_req, 1'b0);
    check("rst.stall", stall, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.exc_valid", exc_valid, 1'b0);
    check("rst.load_data", load_data, 32'h0);
    check("rst.dm_wstrb", dm_wstrb, 4'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].we, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd, vecs[i].dly, o, fin);
      compare($sformatf("vec%0d", i), o, fin, vecs[i].exp);
    end

    // Reset while a request is outstanding.
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; func3 = 3'd2; addr = 32'h40; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("midreq.dm_req_before", dm_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("midreq.dm_req", dm_req, 1'b0);
    check("midreq.stall", stall, 1'b0);
    check("midreq.load_data", load_data, 32'h0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(1'b0, 3'd2, 32'h80, 32'h0, 32'hCAFEF00D, 1, o, fin);
    e = model(1'b0, 3'd2, 32'h80, 32'h0, 32'hCAFEF00D, 1, 32'h0);
    compare("post_rst", o, fin, e);
    cur_ld = e.ld;

    // Randomized ops against the behavioural model.
    for (int i = 0; i < 150; i++) begin
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a, r_wd, r_rd;
      int          r_d;
      r_we = 1'($urandom_range(0, 1));
      r_f3 = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_wd = $urandom;
      r_rd = $urandom;
      r_d  = $urandom_range(0, 5);
      e = model(r_we, r_f3, r_a, r_wd, r_rd, r_d, cur_ld);
      run_op(r_we, r_f3, r_a, r_wd, r_rd, r_d, o, fin);
      compare($sformatf("rnd%0d", i), o, fin, e);
      cur_ld = e.ld;
    end

    @(negedge clk);
    dm_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
